seq_carry_increment_adder: RTL and testbench
============================================

Name: seq_carry_increment_adder

Overview:
Multi-cycle, handshaked implementation of the 32-bit carry-increment add with Cin, sum, Cout and signed overflow. It sits on the consumer side of the operand/result interface used by our adder benches. A requester presents a, b and Cin with a start pulse. The block processes one BLOCK-bit slice per clock using carry-increment selection and reports sum, Cout and of with a one-cycle done pulse. It is the area-lean sibling of the combinational adders, for datapaths that can tolerate WIDTH/BLOCK cycles of latency.

Parameters:
WIDTH, 32, operand and sum width; must be an integer multiple of BLOCK.
BLOCK, 4, bits processed per cycle (carry-increment group size).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
a  input  WIDTH  operand A, two's complement; captured on an accepted start.
b  input  WIDTH  operand B, two's complement; captured on an accepted start.
Cin  input  1  carry-in; captured on an accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when the result becomes valid.
sum  output  WIDTH  registered sum (a+b+Cin) mod 2^WIDTH.
Cout  output  1  carry out of bit WIDTH-1.
of  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, sum=0, Cout=0, of=0; slice counter=0; operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, latch a, b and Cin into internal registers and go to RUN. Counter=0, running carry=Cin, sum cleared to 0.
- RUN: busy=1. Each cycle handles slice k = counter, covering bits [k*BLOCK +: BLOCK]:
  - Compute s0 = slice add with carry-in 0 and s1 = slice add with carry-in 1.
  - Select s1 if the running carry is 1, otherwise s0. Write the selected bits into sum[k*BLOCK +: BLOCK].
  - Update the running carry from the selected slice's carry-out.
- RUN, last slice (counter = WIDTH/BLOCK-1):
  - Also register Cout = final carry and of = (carry into bit WIDTH-1) XOR final carry.
  - Go to DONE.
- DONE: done=1 for exactly this cycle, busy=0.
  - With start=1, accept new operands exactly as IDLE does and go to RUN (back-to-back, no bubble).
  - Otherwise go to IDLE.
- Latency: start accepted at edge N; done high during the cycle after edge N+WIDTH/BLOCK. With defaults, done appears 8 clocks after acceptance.
- Output hold: sum, Cout and of hold their last result in IDLE and DONE, until the next accepted start clears sum. Treat them as valid only while done=1 or after done while in IDLE.
- start during RUN is ignored and has no side effects. Changes to a, b or Cin during RUN do not affect the result.
- Arithmetic: unsigned modular sum; Cout is unsigned carry. of is set only when operand signs are equal and the sum sign differs.
- Reset asserted mid-RUN aborts the operation; no done pulse is produced.
- Counter width is ceil(log2(WIDTH/BLOCK)). It wraps to 0 only by re-entry from IDLE/DONE, never by overflow.

Test Plan:
- a=32'h7fffffff, b=32'h7fffffff, Cin=0, start pulse -> done exactly 8 cycles later; sum=32'hfffffffe, Cout=0, of=1; busy high for 8 cycles.
- a=32'h8fffffff, b=32'h8fffffff, Cin=0 -> sum=32'h1ffffffe, Cout=1, of=1. Then a=32'hAF, b=32'hAF, Cin=1 -> sum=32'h0000015f, Cout=0, of=0.
- a=32'h7AA, b=32'hffffffff, Cin=0; pulse start again 3 cycles into RUN with a=1, b=1 -> second start ignored; result sum=32'h000007a9, Cout=1, of=0, with a single done.
- Back-to-back: hold start=1 in the DONE cycle with a=32'h0, b=32'hffffffff -> no idle bubble; second done 8 cycles later with sum=32'hffffffff, Cout=0, of=0.
- Start a=32'hfffff999, b=32'h111; assert rst asynchronously mid-cycle at cycle 4 -> outputs 0 immediately, no done pulse. A fresh start then gives sum=32'hfffffaaa, Cout=0, of=0.
- Randomized 1000 operand pairs against a reference model of {Cout,sum}=a+b+Cin and the of rule; also run with BLOCK=8 (latency 4).

Source files
------------

// File: rtl/seq_carry_increment_adder.sv
`timescale 1ns/1ps
// Multi-cycle carry-increment adder: one BLOCK-bit slice per clock, both slice
// sums precomputed and the running carry selects between them.
module seq_carry_increment_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             of
);
    localparam int NSLICE = WIDTH / BLOCK;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg, cout_reg, of_reg;

    logic [BLOCK-1:0] a_slice [NSLICE];
    logic [BLOCK-1:0] b_slice [NSLICE];

    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign a_slice[gi] = a_reg[gi*BLOCK +: BLOCK];
            assign b_slice[gi] = b_reg[gi*BLOCK +: BLOCK];
        end
    endgenerate

    logic [BLOCK-1:0] cur_a, cur_b;
    logic [BLOCK:0]   s0, s1, sel;
    logic             msb_cin;
    logic             accept;

    always_comb begin
        cur_a   = a_slice[cnt_reg];
        cur_b   = b_slice[cnt_reg];
        s0      = {1'b0, cur_a} + {1'b0, cur_b};
        s1      = s0 + (BLOCK+1)'(1);
        sel     = carry_reg ? s1 : s0;
        // Carry into the slice MSB recovered from its sum bit; only used on the last slice.
        msb_cin = sel[BLOCK-1] ^ cur_a[BLOCK-1] ^ cur_b[BLOCK-1];
    end

    assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_reg == LAST) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            of_reg    <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= Cin;
            cnt_reg   <= '0;
            sum_reg   <= '0;
        end else if (state_reg == RUN) begin
            for (int k = 0; k < NSLICE; k++) begin
                if (cnt_reg == CW'(k)) sum_reg[k*BLOCK +: BLOCK] <= sel[BLOCK-1:0];
            end
            carry_reg <= sel[BLOCK];
            if (cnt_reg == LAST) begin
                cout_reg <= sel[BLOCK];
                of_reg   <= msb_cin ^ sel[BLOCK];
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign sum  = sum_reg;
    assign Cout = cout_reg;
    assign of   = of_reg;

endmodule

// File: tb/tb_seq_carry_increment_adder.sv
`timescale 1ns/1ps
// Bench for seq_carry_increment_adder: directed table, multi-cycle corner
// sequences and random operands, on BLOCK=4 and BLOCK=8 instances side by side.
module tb_seq_carry_increment_adder;
    logic        clk = 1'b0;
    logic        rst, start, cin;
    logic [31:0] a, b;
    logic        busy4, done4, cout4, of4;
    logic [31:0] sum4;
    logic        busy8, done8, cout8, of8;
    logic [31:0] sum8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_carry_increment_adder #(.WIDTH(32), .BLOCK(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .Cin(cin),
        .busy(busy4), .done(done4), .sum(sum4), .Cout(cout4), .of(of4)
    );

    seq_carry_increment_adder #(.WIDTH(32), .BLOCK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .Cin(cin),
        .busy(busy8), .done(done8), .sum(sum8), .Cout(cout8), .of(of8)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // Launch one operation and check both instances' latency and result.
    task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic ic, input logic [31:0] es, input logic eco, input logic eof);
        int lat4, lat8, bcnt;
        logic [31:0] s4, s8;
        logic c4, c8, o4, o8;
        lat4 = 0; lat8 = 0; bcnt = 0;
        s4 = '0; s8 = '0; c4 = 0; c8 = 0; o4 = 0; o8 = 0;
        a = ia; b = ib; cin = ic; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (busy4) bcnt++;
            step();
            if (done4 && lat4 == 0) begin lat4 = i; s4 = sum4; c4 = cout4; o4 = of4; end
            if (done8 && lat8 == 0) begin lat8 = i; s8 = sum8; c8 = cout8; o8 = of8; end
            if (lat4 != 0 && lat8 != 0) break;
        end
        chk({tag, "_lat4"}, lat4, 8);
        chk({tag, "_busy4"}, bcnt, 8);
        chk({tag, "_sum4"}, s4, es);
        chk({tag, "_cout4"}, {31'b0, c4}, {31'b0, eco});
        chk({tag, "_of4"}, {31'b0, o4}, {31'b0, eof});
        chk({tag, "_lat8"}, lat8, 4);
        chk({tag, "_sum8"}, s8, es);
        chk({tag, "_cout8"}, {31'b0, c8}, {31'b0, eco});
        chk({tag, "_of8"}, {31'b0, o8}, {31'b0, eof});
        $display("op %s a=%h b=%h cin=%0d sum4=%h cout4=%0d of4=%0d sum8=%h lat4=%0d lat8=%0d",
                 tag, ia, ib, ic, s4, c4, o4, s8, lat4, lat8);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, lat, found;
        logic [31:0] ra, rb, rs, cs;
        logic rc, rco, rov, cco, cov;

        vecs[0] = '{32'h7fffffff, 32'h7fffffff, 1'b0, 32'hfffffffe, 1'b0, 1'b1};
        vecs[1] = '{32'h8fffffff, 32'h8fffffff, 1'b0, 32'h1ffffffe, 1'b1, 1'b1};
        vecs[2] = '{32'h000000af, 32'h000000af, 1'b1, 32'h0000015f, 1'b0, 1'b0};
        vecs[3] = '{32'h000007aa, 32'hffffffff, 1'b0, 32'h000007a9, 1'b1, 1'b0};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[5] = '{32'hffffffff, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[6] = '{32'h7fffffff, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1};
        vecs[7] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        chk("rst_busy", {31'b0, busy4}, 0);
        chk("rst_done", {31'b0, done4}, 0);
        chk("rst_sum", sum4, 0);
        chk("rst_cout", {31'b0, cout4}, 0);
        chk("rst_of", {31'b0, of4}, 0);
        chk("rst_busy8", {31'b0, busy8}, 0);
        @(negedge clk) rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].s, vecs[i].co, vecs[i].ov);
        end

        // start during RUN must be ignored
        a = 32'h7aa; b = 32'hffffffff; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        a = 32'h1; b = 32'h1; start = 1'b1;
        step();
        start = 1'b0;
        nd = 0; lat = 0; rs = '0; rco = 0; rov = 0;
        for (int i = 4; i <= 24; i++) begin
            step();
            if (done4) begin
                nd++;
                if (lat == 0) begin lat = i; rs = sum4; rco = cout4; rov = of4; end
            end
        end
        chk("ign_ndone", nd, 1);
        chk("ign_lat", lat, 8);
        chk("ign_sum", rs, 32'h000007a9);
        chk("ign_cout", {31'b0, rco}, 1);
        chk("ign_of", {31'b0, rov}, 0);
        $display("op ignore_start sum=%h cout=%0d of=%0d dones=%0d lat=%0d", rs, rco, rov, nd, lat);

        // back-to-back start held in the DONE cycle
        a = 32'h7fffffff; b = 32'h7fffffff; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done4) begin found = 1; break; end
        end
        chk("b2b_first_done", found, 1);
        a = 32'h0; b = 32'hffffffff; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_nobubble", {31'b0, busy4}, 1);
        lat = 0; rs = '0; rco = 0; rov = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done4) begin lat = i; rs = sum4; rco = cout4; rov = of4; break; end
        end
        chk("b2b_lat", lat, 8);
        chk("b2b_sum", rs, 32'hffffffff);
        chk("b2b_cout", {31'b0, rco}, 0);
        chk("b2b_of", {31'b0, rov}, 0);
        $display("op back_to_back sum=%h cout=%0d of=%0d lat=%0d", rs, rco, rov, lat);
        step();
        step();

        // asynchronous reset in the middle of RUN
        a = 32'hfffff999; b = 32'h111; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        #3 rst = 1'b1;
        #1;
        chk("arst_sum", sum4, 0);
        chk("arst_busy", {31'b0, busy4}, 0);
        chk("arst_done", {31'b0, done4}, 0);
        chk("arst_sum8", sum8, 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done4 || done8) nd++;
        end
        chk("arst_nodone", nd, 0);
        $display("op mid_run_reset dones_after=%0d", nd);
        run_op("after_rst", 32'hfffff999, 32'h111, 1'b0, 32'hfffffaaa, 1'b0, 1'b0);

        // random operands against plain arithmetic
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            {cco, cs} = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
            cov = (ra[31] == rb[31]) && (cs[31] != ra[31]);
            run_op($sformatf("rnd%0d", n), ra, rb, rc, cs, cco, cov);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
